// File: rtl/fifo_pkg.sv
// Shared definitions for fifo_flex: read-mode encodings and pointer width helper.
package fifo_pkg;

   localparam int unsigned FIFO_MODE_STD  = 0;
   localparam int unsigned FIFO_MODE_FWFT = 1;

   // Address bits plus one wrap bit.
   function automatic int unsigned fifo_ptr_w(input int unsigned depth);
      return $clog2(depth) + 1;
   endfunction

endpackage

// File: rtl/fifo_ptr.sv
// Wrap-bit pointer counter with synchronous clear; wraps naturally modulo 2^PW.
module fifo_ptr #(
   parameter int unsigned PW = 4
) (
   input  logic          clk_i,
   input  logic          clr_i,
   input  logic          inc_i,
   output logic [PW-1:0] ptr_o
);

   logic [PW-1:0] r_ptr;

   always_ff @(posedge clk_i) begin
      if (clr_i) begin
         r_ptr <= '0;
      end else if (inc_i) begin
         r_ptr <= r_ptr + PW'(1);
      end
   end

   assign ptr_o = r_ptr;

endmodule

// File: rtl/fifo_flex.sv
// Single-clock FIFO with occupancy count, threshold flags and optional FWFT read mode.
// Sticky overflow/underflow flags are generated only when FIFO_FLEX_ERR_EN is defined.
module fifo_flex
   import fifo_pkg::*;
#(
   parameter int unsigned WIDTH        = 8,
   parameter int unsigned DEPTH        = 8,
   parameter int unsigned AFULL_LEVEL  = DEPTH - 2,
   parameter int unsigned AEMPTY_LEVEL = 1,
   parameter int unsigned FWFT         = FIFO_MODE_STD
) (
   input  logic                         clk_i,
   input  logic                         reset_i,
   input  logic [WIDTH-1:0]             din_i,
   input  logic                         wr_en_i,
   input  logic                         rd_en_i,
   output logic [WIDTH-1:0]             dout_o,
   output logic                         valid_o,
   output logic                         full_o,
   output logic                         empty_o,
   output logic                         almost_full_o,
   output logic                         almost_empty_o,
   output logic [fifo_ptr_w(DEPTH)-1:0] count_o,
   output logic                         overflow_o,
   output logic                         underflow_o
);

   localparam int unsigned AW = $clog2(DEPTH);
   localparam int unsigned PW = fifo_ptr_w(DEPTH);
   localparam logic [PW-1:0] AFULL_C  = PW'(AFULL_LEVEL);
   localparam logic [PW-1:0] AEMPTY_C = PW'(AEMPTY_LEVEL);

   if (WIDTH < 1) begin : g_bad_width
      $error("fifo_flex: WIDTH must be at least 1");
   end
   if ((DEPTH < 2) || ((DEPTH & (DEPTH - 1)) != 0)) begin : g_bad_depth
      $error("fifo_flex: DEPTH must be a power of two and at least 2");
   end
   if ((AFULL_LEVEL < 1) || (AFULL_LEVEL > DEPTH)) begin : g_bad_afull
      $error("fifo_flex: AFULL_LEVEL must be in 1..DEPTH");
   end
   if (AEMPTY_LEVEL > DEPTH - 1) begin : g_bad_aempty
      $error("fifo_flex: AEMPTY_LEVEL must be in 0..DEPTH-1");
   end
   if (FWFT > FIFO_MODE_FWFT) begin : g_bad_mode
      $error("fifo_flex: FWFT must be 0 or 1");
   end

   logic [WIDTH-1:0] r_mem [DEPTH];

   logic [PW-1:0] w_wr_ptr;
   logic [PW-1:0] w_rd_ptr;
   logic [PW-1:0] w_wr_ptr_nxt;
   logic [PW-1:0] w_rd_ptr_nxt;
   logic [PW-1:0] w_count_nxt;
   logic [AW-1:0] w_rd_addr;
   logic          w_wr_acc;
   logic          w_rd_acc;
   logic          w_full_nxt;
   logic          w_empty_nxt;

   logic [PW-1:0] r_count;
   logic          r_full;
   logic          r_empty;
   logic          r_afull;
   logic          r_aempty;

   assign w_wr_acc  = wr_en_i && !r_full;
   assign w_rd_acc  = rd_en_i && !r_empty;
   assign w_rd_addr = w_rd_ptr[AW-1:0];

   fifo_ptr #(.PW(PW)) u_wr_ptr (
      .clk_i (clk_i),
      .clr_i (reset_i),
      .inc_i (w_wr_acc),
      .ptr_o (w_wr_ptr)
   );

   fifo_ptr #(.PW(PW)) u_rd_ptr (
      .clk_i (clk_i),
      .clr_i (reset_i),
      .inc_i (w_rd_acc),
      .ptr_o (w_rd_ptr)
   );

   // Flags are precomputed from the post-edge pointers so they track count_o exactly.
   always_comb begin
      w_wr_ptr_nxt = w_wr_ptr + PW'(w_wr_acc);
      w_rd_ptr_nxt = w_rd_ptr + PW'(w_rd_acc);
      w_count_nxt  = r_count + PW'(w_wr_acc) - PW'(w_rd_acc);
      w_full_nxt   = (w_wr_ptr_nxt[PW-1] != w_rd_ptr_nxt[PW-1]) &&
                     (w_wr_ptr_nxt[AW-1:0] == w_rd_ptr_nxt[AW-1:0]);
      w_empty_nxt  = (w_wr_ptr_nxt == w_rd_ptr_nxt);
   end

   always_ff @(posedge clk_i) begin
      if (reset_i) begin
         r_count  <= '0;
         r_full   <= 1'b0;
         r_empty  <= 1'b1;
         r_afull  <= 1'b0;
         r_aempty <= 1'b1;
      end else begin
         r_count  <= w_count_nxt;
         r_full   <= w_full_nxt;
         r_empty  <= w_empty_nxt;
         r_afull  <= (w_count_nxt >= AFULL_C);
         r_aempty <= (w_count_nxt <= AEMPTY_C);
      end
   end

   // Storage is deliberately not reset.
   always_ff @(posedge clk_i) begin
      if (w_wr_acc && !reset_i) begin
         r_mem[w_wr_ptr[AW-1:0]] <= din_i;
      end
   end

   if (FWFT == FIFO_MODE_FWFT) begin : g_fwft
      assign dout_o  = r_mem[w_rd_addr];
      assign valid_o = !r_empty;
   end else begin : g_std
      logic [WIDTH-1:0] r_dout;
      logic             r_valid;

      always_ff @(posedge clk_i) begin
         if (reset_i) begin
            r_dout  <= '0;
            r_valid <= 1'b0;
         end else begin
            r_valid <= w_rd_acc;
            if (w_rd_acc) begin
               r_dout <= r_mem[w_rd_addr];
            end
         end
      end

      assign dout_o  = r_dout;
      assign valid_o = r_valid;
   end

`ifdef FIFO_FLEX_ERR_EN
   logic r_overflow;
   logic r_underflow;

   // Sticky until reset: any request presented against a full/empty FIFO.
   always_ff @(posedge clk_i) begin
      if (reset_i) begin
         r_overflow  <= 1'b0;
         r_underflow <= 1'b0;
      end else begin
         if (wr_en_i && r_full) begin
            r_overflow <= 1'b1;
         end
         if (rd_en_i && r_empty) begin
            r_underflow <= 1'b1;
         end
      end
   end

   assign overflow_o  = r_overflow;
   assign underflow_o = r_underflow;
`else
   assign overflow_o  = 1'b0;
   assign underflow_o = 1'b0;
`endif

   assign full_o         = r_full;
   assign empty_o        = r_empty;
   assign almost_full_o  = r_afull;
   assign almost_empty_o = r_aempty;
   assign count_o        = r_count;

endmodule

// File: tb/tb_fifo_flex.sv
// Directed bench for fifo_flex: standard-mode instance driven from a vector table plus
// hand sequences, and an FWFT instance; expected error flags follow FIFO_FLEX_ERR_EN.
module tb_fifo_flex;

`ifdef FIFO_FLEX_ERR_EN
   localparam bit ERR = 1'b1;
`else
   localparam bit ERR = 1'b0;
`endif

   typedef struct {
      logic       wr;
      logic       rd;
      logic [7:0] din;
      int         count;
      logic       valid;
      logic [7:0] dout;
      logic       ovf;
      logic       udf;
   } vec_t;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic       reset_i;
   logic [7:0] s_din;
   logic       s_wr;
   logic       s_rd;
   logic [7:0] s_dout;
   logic       s_valid, s_full, s_empty, s_afull, s_aempty, s_ovf, s_udf;
   logic [3:0] s_count;

   logic [7:0] f_din;
   logic       f_wr;
   logic       f_rd;
   logic [7:0] f_dout;
   logic       f_valid, f_full, f_empty, f_afull, f_aempty, f_ovf, f_udf;
   logic [3:0] f_count;

   int n_checks = 0;
   int n_fail   = 0;
   vec_t vecs[$];

   fifo_flex #(.WIDTH(8), .DEPTH(8), .AFULL_LEVEL(6), .AEMPTY_LEVEL(1), .FWFT(0)) u_std (
      .clk_i(clk), .reset_i(reset_i), .din_i(s_din), .wr_en_i(s_wr), .rd_en_i(s_rd),
      .dout_o(s_dout), .valid_o(s_valid), .full_o(s_full), .empty_o(s_empty),
      .almost_full_o(s_afull), .almost_empty_o(s_aempty), .count_o(s_count),
      .overflow_o(s_ovf), .underflow_o(s_udf)
   );

   fifo_flex #(.WIDTH(8), .DEPTH(8), .AFULL_LEVEL(6), .AEMPTY_LEVEL(1), .FWFT(1)) u_fwft (
      .clk_i(clk), .reset_i(reset_i), .din_i(f_din), .wr_en_i(f_wr), .rd_en_i(f_rd),
      .dout_o(f_dout), .valid_o(f_valid), .full_o(f_full), .empty_o(f_empty),
      .almost_full_o(f_afull), .almost_empty_o(f_aempty), .count_o(f_count),
      .overflow_o(f_ovf), .underflow_o(f_udf)
   );

   task automatic check(input string name, input int got, input int exp);
      n_checks++;
      if (got != exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, got, exp, $time);
      end
   endtask

   task automatic cyc();
      @(posedge clk);
      #1;
   endtask

   task automatic add(input logic wr, input logic rd, input logic [7:0] din, input int count,
                      input logic valid, input logic [7:0] dout, input logic ovf, input logic udf);
      vec_t v;
      v.wr = wr; v.rd = rd; v.din = din; v.count = count;
      v.valid = valid; v.dout = dout; v.ovf = ovf & ERR; v.udf = udf & ERR;
      vecs.push_back(v);
   endtask

   task automatic check_std_flags(input string tag, input int c);
      check({tag, "_count"},  int'(s_count),  c);
      check({tag, "_full"},   int'(s_full),   int'(c == 8));
      check({tag, "_empty"},  int'(s_empty),  int'(c == 0));
      check({tag, "_afull"},  int'(s_afull),  int'(c >= 6));
      check({tag, "_aempty"}, int'(s_aempty), int'(c <= 1));
   endtask

   initial begin
      reset_i = 1'b1;
      s_din = '0; s_wr = 1'b0; s_rd = 1'b0;
      f_din = '0; f_wr = 1'b0; f_rd = 1'b0;

      // Fill 0x01..0x08 then drain in order.
      for (int k = 1; k <= 8; k++) add(1'b1, 1'b0, 8'(k), k, 1'b0, 8'h00, 1'b0, 1'b0);
      for (int j = 1; j <= 8; j++) add(1'b0, 1'b1, 8'h00, 8 - j, 1'b1, 8'(j), 1'b0, 1'b0);
      add(1'b0, 1'b0, 8'h00, 0, 1'b0, 8'h08, 1'b0, 1'b0);
      // Full with read+write: read wins, 0xAA dropped.
      for (int k = 0; k < 8; k++) add(1'b1, 1'b0, 8'(8'h10 + k), k + 1, 1'b0, 8'h08, 1'b0, 1'b0);
      add(1'b1, 1'b1, 8'hAA, 7, 1'b1, 8'h10, 1'b1, 1'b0);
      for (int j = 1; j <= 7; j++) add(1'b0, 1'b1, 8'h00, 7 - j, 1'b1, 8'(8'h10 + j), 1'b1, 1'b0);
      // Empty with read+write: write wins, no valid.
      add(1'b1, 1'b1, 8'h33, 1, 1'b0, 8'h17, 1'b1, 1'b1);
      add(1'b0, 1'b1, 8'h00, 0, 1'b1, 8'h33, 1'b1, 1'b1);
      add(1'b0, 1'b1, 8'h00, 0, 1'b0, 8'h33, 1'b1, 1'b1);

      cyc();
      cyc();
      reset_i = 1'b0;
      check_std_flags("rst", 0);
      check("rst_valid", int'(s_valid), 0);
      check("rst_dout",  int'(s_dout),  0);
      check("rst_ovf",   int'(s_ovf),   0);
      check("rst_udf",   int'(s_udf),   0);
      check("rst_f_valid",  int'(f_valid),  0);
      check("rst_f_empty",  int'(f_empty),  1);
      check("rst_f_full",   int'(f_full),   0);
      check("rst_f_afull",  int'(f_afull),  0);
      check("rst_f_aempty", int'(f_aempty), 1);
      check("rst_f_count",  int'(f_count),  0);
      check("rst_f_ovf",    int'(f_ovf),    0);
      check("rst_f_udf",    int'(f_udf),    0);

      foreach (vecs[i]) begin
         s_wr = vecs[i].wr; s_rd = vecs[i].rd; s_din = vecs[i].din;
         cyc();
         check_std_flags($sformatf("v%0d", i), vecs[i].count);
         check($sformatf("v%0d_valid", i), int'(s_valid), int'(vecs[i].valid));
         check($sformatf("v%0d_dout", i),  int'(s_dout),  int'(vecs[i].dout));
         check($sformatf("v%0d_ovf", i),   int'(s_ovf),   int'(vecs[i].ovf));
         check($sformatf("v%0d_udf", i),   int'(s_udf),   int'(vecs[i].udf));
      end

      // Interleaved write/read pairs wrap both pointers twice.
      for (int i = 0; i < 20; i++) begin
         s_wr = 1'b1; s_rd = 1'b0; s_din = 8'(i);
         cyc();
         check($sformatf("wrap%0d_wcount", i), int'(s_count), 1);
         check($sformatf("wrap%0d_full", i),   int'(s_full),  0);
         s_wr = 1'b0; s_rd = 1'b1;
         cyc();
         check($sformatf("wrap%0d_dout", i),  int'(s_dout),  i);
         check($sformatf("wrap%0d_valid", i), int'(s_valid), 1);
         check($sformatf("wrap%0d_empty", i), int'(s_empty), 1);
      end
      s_rd = 1'b0;
      check("wrap_ovf_held", int'(s_ovf), int'(ERR));
      check("wrap_udf_held", int'(s_udf), int'(ERR));

      // Reset with 5 entries and a concurrent read request.
      for (int k = 0; k < 5; k++) begin
         s_wr = 1'b1; s_din = 8'(8'h40 + k);
         cyc();
      end
      check("pre_rst_count", int'(s_count), 5);
      reset_i = 1'b1; s_wr = 1'b1; s_rd = 1'b1;
      cyc();
      reset_i = 1'b0; s_wr = 1'b0; s_rd = 1'b0;
      check_std_flags("mid_rst", 0);
      check("mid_rst_valid", int'(s_valid), 0);
      check("mid_rst_dout",  int'(s_dout),  0);
      check("mid_rst_ovf",   int'(s_ovf),   0);
      check("mid_rst_udf",   int'(s_udf),   0);
      cyc();
      check("post_rst_valid", int'(s_valid), 0);
      check("post_rst_count", int'(s_count), 0);

      // FWFT: write falls through one cycle later; pop clears valid.
      f_wr = 1'b1; f_din = 8'h5A;
      cyc();
      f_wr = 1'b0;
      check("fwft_valid", int'(f_valid), 1);
      check("fwft_dout",  int'(f_dout),  8'h5A);
      check("fwft_count", int'(f_count), 1);
      f_rd = 1'b1;
      cyc();
      f_rd = 1'b0;
      check("fwft_pop_valid", int'(f_valid), 0);
      check("fwft_pop_empty", int'(f_empty), 1);
      f_wr = 1'b1; f_din = 8'h11;
      cyc();
      check("fwft_d1", int'(f_dout), 8'h11);
      f_din = 8'h22;
      cyc();
      f_wr = 1'b0;
      check("fwft_d1_hold", int'(f_dout),  8'h11);
      check("fwft_cnt2",    int'(f_count), 2);
      f_rd = 1'b1;
      cyc();
      check("fwft_d2",       int'(f_dout),  8'h22);
      check("fwft_d2_valid", int'(f_valid), 1);
      cyc();
      f_rd = 1'b0;
      check("fwft_end_valid", int'(f_valid), 0);
      check("fwft_end_udf",   int'(f_udf),   0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
